// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared address-range constants, nop encoding and queue entry type.
package fetch_queue_pkg;
  localparam logic [31:0] PC_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT_DEF = 32'h0000_6ffc;
  localparam logic [31:0] NOP          = 32'h0000_0000;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } fq_entry_t;
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch-side and decode-side signals of the fetch queue.
interface fetch_queue_if #(parameter int DEPTH = 4) ();
  logic [31:0]                  if_pc;
  logic [31:0]                  if_instr;
  logic                         if_valid;
  logic                         pc_en;
  logic                         flush;
  logic                         id_valid;
  logic                         id_ready;
  logic [31:0]                  id_pc;
  logic [31:0]                  id_instr;
  logic                         id_exc;
  logic [$clog2(DEPTH+1)-1:0]   count;
  modport slave (
    input  if_pc, if_instr, if_valid, flush, id_ready,
    output pc_en, id_valid, id_pc, id_instr, id_exc, count
  );
  modport master (
    output if_pc, if_instr, if_valid, flush, id_ready,
    input  pc_en, id_valid, id_pc, id_instr, id_exc, count
  );
endinterface

// File: rtl/fetch_queue_addr_check.sv
// fq_addr_check: combinational instruction-address error (AdEL) check.
module fq_addr_check
  import fetch_queue_pkg::*;
#(
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input  logic [31:0] addr_i,
  output logic        adel_o
);
  assign adel_o = (addr_i[1:0] != 2'b00) | (addr_i < PC_BASE) | (addr_i > PC_LIMIT);
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: circular {pc, instr, exc} FIFO between fetch and decode with PC stall and flush.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_BASE  = PC_BASE_DEF,
  parameter logic [31:0] PC_LIMIT = PC_LIMIT_DEF
) (
  input logic            clk,
  input logic            reset,
  fetch_queue_if.slave   q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  fq_entry_t         mem_q [DEPTH];
  fq_entry_t         head, wr_entry;
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              exc, push, pop;
  fq_addr_check #(.PC_BASE(PC_BASE), .PC_LIMIT(PC_LIMIT)) u_chk (
    .addr_i (q.if_pc),
    .adel_o (exc)
  );
  assign q.pc_en    = cnt_q != CW'(DEPTH);
  assign q.id_valid = cnt_q != '0;
  assign q.count    = cnt_q;
  assign push       = q.if_valid & q.pc_en & ~q.flush;
  assign pop        = q.id_valid & q.id_ready & ~q.flush;
  assign wr_entry   = '{pc: q.if_pc, instr: exc ? NOP : q.if_instr, exc: exc};
  assign head       = mem_q[rd_q];
  assign q.id_pc    = q.id_valid ? head.pc : NOP;
  assign q.id_instr = q.id_valid ? head.instr : NOP;
  assign q.id_exc   = q.id_valid & head.exc;
  always_comb begin
    wr_d  = wr_q + AW'(push);
    rd_d  = q.flush ? wr_q : rd_q + AW'(pop);
    cnt_d = q.flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // Storage needs no reset: id_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr_entry;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  fetch_queue_if #(.DEPTH(4)) bus ();
  fetch_queue #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .q(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.if_pc    = 32'h0;
    bus.if_instr = 32'h0;
    bus.if_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.id_ready = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    bus.if_valid = 1'b1;
    bus.if_pc    = pc;
    bus.if_instr = instr;
    tick();
    bus.if_valid = 1'b0;
  endtask

  task automatic drain();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus.id_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %0b want 0", bus.id_valid); end
    n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL reset_id_pc got %h want 0", bus.id_pc); end
    n_cmp++; if (bus.id_instr !== 32'h0) begin n_err++; $display("FAIL reset_id_instr got %h want 0", bus.id_instr); end
    n_cmp++; if (bus.id_exc !== 1'b0) begin n_err++; $display("FAIL reset_id_exc got %0b want 0", bus.id_exc); end
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL reset_pc_en got %0b want 1", bus.pc_en); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
  endtask

  task automatic test_single();
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h3000;
    bus.if_instr = 32'h2401_0001;
    #1;
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass_valid got %0b want 0", bus.id_valid); end
    tick();
    bus.if_valid = 1'b0;
    n_cmp++; if (bus.id_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0b want 1", bus.id_valid); end
    n_cmp++; if (bus.id_pc !== 32'h3000) begin n_err++; $display("FAIL single_pc got %h want 00003000", bus.id_pc); end
    n_cmp++; if (bus.id_instr !== 32'h2401_0001) begin n_err++; $display("FAIL single_instr got %h want 24010001", bus.id_instr); end
    n_cmp++; if (bus.id_exc !== 1'b0) begin n_err++; $display("FAIL single_exc got %0b want 0", bus.id_exc); end
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL single_count got %0d want 1", bus.count); end
    tick();
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL hold_count got %0d want 1", bus.count); end
    bus.id_ready = 1'b1;
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL pop_count got %0d want 0", bus.count); end
    tick();
    bus.id_ready = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL empty_underflow got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL fill_pc_en%0d got %0b want 1", i, bus.pc_en); end
      push(32'h3000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    end
    n_cmp++; if (bus.pc_en !== 1'b0) begin n_err++; $display("FAIL full_pc_en got %0b want 0", bus.pc_en); end
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d want 4", bus.count); end
    push(32'h3010, 32'h1000_0004);
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL ignored_count got %0d want 4", bus.count); end
    n_cmp++; if (bus.id_pc !== 32'h3000) begin n_err++; $display("FAIL ignored_head got %h want 00003000", bus.id_pc); end
    bus.id_ready = 1'b1;
    tick();
    bus.id_ready = 1'b0;
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL freed_pc_en got %0b want 1", bus.pc_en); end
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL freed_count got %0d want 3", bus.count); end
    n_cmp++; if (bus.id_pc !== 32'h3004) begin n_err++; $display("FAIL freed_head got %h want 00003004", bus.id_pc); end
    n_cmp++; if (bus.id_instr !== 32'h1000_0001) begin n_err++; $display("FAIL freed_instr got %h want 10000001", bus.id_instr); end
    bus.id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.id_pc !== 32'h3004 + 32'(4 * i)) begin n_err++; $display("FAIL order%0d got %h want %h", i, bus.id_pc, 32'h3004 + 32'(4 * i)); end
      tick();
    end
    bus.id_ready = 1'b0;
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL drained_valid got %0b want 0", bus.id_valid); end
  endtask

  task automatic test_back_to_back();
    push(32'h3100, 32'hA000_0000);
    for (int i = 0; i < 10; i++) begin
      bus.if_valid = 1'b1;
      bus.if_pc    = 32'h3104 + 32'(4 * i);
      bus.if_instr = 32'hA000_0001 + 32'(i);
      bus.id_ready = 1'b1;
      tick();
      n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL b2b_count%0d got %0d want 1", i, bus.count); end
      n_cmp++; if (bus.id_pc !== 32'h3104 + 32'(4 * i)) begin n_err++; $display("FAIL b2b_pc%0d got %h want %h", i, bus.id_pc, 32'h3104 + 32'(4 * i)); end
      n_cmp++; if (bus.id_instr !== 32'hA000_0001 + 32'(i)) begin n_err++; $display("FAIL b2b_instr%0d got %h want %h", i, bus.id_instr, 32'hA000_0001 + 32'(i)); end
    end
    bus.if_valid = 1'b0;
    drain();
  endtask

  task automatic test_flush();
    push(32'h3200, 32'hB000_0000);
    push(32'h3204, 32'hB000_0001);
    push(32'h3208, 32'hB000_0002);
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL preflush_count got %0d want 3", bus.count); end
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h320c;
    bus.if_instr = 32'hB000_0003;
    bus.id_ready = 1'b1;
    bus.flush    = 1'b1;
    tick();
    idle_inputs();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %0b want 0", bus.id_valid); end
    n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL flush_pc got %h want 0", bus.id_pc); end
    push(32'h3300, 32'hC000_0000);
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL postflush_count got %0d want 1", bus.count); end
    n_cmp++; if (bus.id_pc !== 32'h3300) begin n_err++; $display("FAIL postflush_pc got %h want 00003300", bus.id_pc); end
    n_cmp++; if (bus.id_instr !== 32'hC000_0000) begin n_err++; $display("FAIL postflush_instr got %h want c0000000", bus.id_instr); end
    drain();
  endtask

  task automatic test_exc();
    logic [31:0] pcs   [4] = '{32'h3002, 32'h2ffc, 32'h7000, 32'h6ffc};
    logic [31:0] instrs[4] = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
    logic        excs  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) push(pcs[i], 32'hDEAD_BEEF);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.id_pc !== pcs[i]) begin n_err++; $display("FAIL exc_pc%0d got %h want %h", i, bus.id_pc, pcs[i]); end
      n_cmp++; if (bus.id_exc !== excs[i]) begin n_err++; $display("FAIL exc_flag%0d got %0b want %0b", i, bus.id_exc, excs[i]); end
      n_cmp++; if (bus.id_instr !== instrs[i]) begin n_err++; $display("FAIL exc_instr%0d got %h want %h", i, bus.id_instr, instrs[i]); end
      tick();
    end
    bus.id_ready = 1'b0;
    n_cmp++; if (bus.id_exc !== 1'b0) begin n_err++; $display("FAIL exc_empty got %0b want 0", bus.id_exc); end
  endtask

  task automatic test_reset_mid();
    push(32'h3400, 32'hE000_0000);
    push(32'h3404, 32'hE000_0001);
    bus.if_valid = 1'b1;
    bus.if_pc    = 32'h3408;
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL async_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.id_valid !== 1'b0) begin n_err++; $display("FAIL async_valid got %0b want 0", bus.id_valid); end
    n_cmp++; if (bus.id_pc !== 32'h0) begin n_err++; $display("FAIL async_pc got %h want 0", bus.id_pc); end
    n_cmp++; if (bus.id_instr !== 32'h0) begin n_err++; $display("FAIL async_instr got %h want 0", bus.id_instr); end
    n_cmp++; if (bus.pc_en !== 1'b1) begin n_err++; $display("FAIL async_pc_en got %0b want 1", bus.pc_en); end
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL held_count got %0d want 0", bus.count); end
    idle_inputs();
    reset = 1'b0;
    push(32'h3500, 32'hF000_0000);
    n_cmp++; if (bus.id_pc !== 32'h3500) begin n_err++; $display("FAIL after_reset_pc got %h want 00003500", bus.id_pc); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_exc();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
